dmem_copy_dma: RTL and testbench
================================

// Module: dmem_copy_dma
// PURPOSE
//  Word-copy DMA engine acting as the initiator on the data-memory port
//  (addr/write_data/memread/memwrite/sign_mask out; read_data/clk_stall in).
//  Copies LEN words from SRC to DST as alternating read and write transactions.
//  Sits beside the core's load/store path; the top-level arbiter grants the port to it.
// PARAMETERS
//  ADDR_W      32   byte-address width on the memory port
//  LEN_W       10   word-count width (max 1023 words = data memory depth)
//  TIMEOUT     15   cycles to wait for clk_stall to rise before flagging err
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse, sampled only in IDLE
//  abort        in   1       level; stop after the in-flight transaction
//  src_addr     in   ADDR_W  source byte address, word aligned
//  dst_addr     in   ADDR_W  destination byte address, word aligned
//  len_words    in   LEN_W   number of words to copy
//  busy         out  1       high from the cycle after start until done/err
//  done         out  1       1-cycle pulse on successful completion or abort
//  err          out  1       sticky until the next start: misalignment or timeout
//  words_done   out  LEN_W   count of words fully written
//  addr         out  ADDR_W  memory-port byte address
//  write_data   out  32      memory-port write data
//  memread      out  1       memory-port read request (1-cycle pulse)
//  memwrite     out  1       memory-port write request (1-cycle pulse)
//  sign_mask    out  4       fixed 4'b0100 (word, unsigned) while memread/memwrite are high; 0 otherwise
//  read_data    in   32      memory-port read data
//  clk_stall    in   1       responder busy flag
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE; the internal word buffer, pointers and count are cleared.
//  Port protocol: the request is held high for exactly one cycle (the issue cycle).
//   The responder raises clk_stall at that edge, then drops it on a later edge.
//   The transaction is complete at the first edge where clk_stall==0 and the
//   stall_seen flag is set. read_data is captured at that edge.
//  States: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> (RD_REQ | FINISH) -> IDLE; any -> ERROR -> IDLE.
//  IDLE: on start, latch src, dst and len, and clear words_done and err.
//   - If len==0: pulse done on the next cycle with no port activity.
//   - If src[1:0]!=0 or dst[1:0]!=0: go to ERROR with no port activity.
//  RD_REQ: memread=1, addr=src_ptr. Next state is RD_WAIT.
//  RD_WAIT: wait for stall_seen, then clk_stall==0. Capture read_data into the word buffer and go to WR_REQ.
//  WR_REQ: memwrite=1, addr=dst_ptr, write_data=buffer. Next state is WR_WAIT.
//  WR_WAIT: on completion, src_ptr+=4, dst_ptr+=4 and words_done+=1.
//   - If words_done==len or abort is set: go to FINISH.
//   - Otherwise go to RD_REQ.
//  abort raised during RD_WAIT: the read completes, the write is skipped, then FINISH.
//  Timeout: a wait counter starts in each *_WAIT state. If clk_stall has not risen
//   within TIMEOUT cycles, go to ERROR.
//  FINISH: done=1 for 1 cycle, busy drops in the same cycle, then IDLE.
//  ERROR: err=1 (sticky), busy=0, no done pulse, then IDLE.
//  start while busy is ignored.
//  Pointers wrap modulo 2^ADDR_W. There is no range check: the software guarantees
//   regions lie inside data memory. A dst of 0x2000 drives the LED register normally.
//  Async reset mid-transaction: outputs drop immediately. The responder still
//   finishes its latched transaction, so a write already issued lands in memory.
// STRUCTURE
//  Shared package/defines: FSM state encodings, SIGN_MASK_WORD=4'b0100,
//   data memory base address.
//  Sub-module: dmem_port_txn, which issues one request pulse and tracks
//   stall_seen, completion and timeout. It is instantiated once and reused
//   for reads and writes.
// TESTING
//  1 src=0x1000, dst=0x1100, len=4, memory preloaded with 0xA0..A3:
//    -> dst holds the same 4 words; words_done=4; done pulses once.
//    -> 8 transactions, each request high for exactly 1 cycle.
//  2 len=0 -> done pulses 1 cycle after start; memread and memwrite never asserted; err=0.
//  3 src=0x1002 -> err=1, no port activity, no done. A following valid start clears err.
//  4 abort during the 2nd RD_WAIT of len=5 -> 1 word written;
//    2nd read completes with no write; words_done=1; done pulses.
//  5 Stubbed responder never raises clk_stall -> err asserted at
//    TIMEOUT+1 cycles after the request; busy=0.
//  6 rst_n low during WR_WAIT -> outputs 0 asynchronously. After release,
//    a new len=2 copy completes correctly.

Source files
------------

// File: rtl/dmem_copy_dma_pkg.sv
// Shared types and constants for the word-copy DMA engine.
package dmem_copy_dma_pkg;

    // Copy engine FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_FINISH  = 3'd5,
        ST_ERROR   = 3'd6
    } state_e;

    // Word access, unsigned, on the data-memory port
    localparam logic [3:0]  SIGN_MASK_WORD = 4'b0100;

    // Start of data memory in the byte address map
    localparam logic [31:0] DMEM_BASE = 32'h0000_1000;

    // Byte address is word aligned when its two LSBs are zero
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_copy_dma_port_txn.sv
// Single memory-port transaction tracker: request pulse, stall_seen,
// completion and timeout. Reused for both reads and writes.
module dmem_port_txn #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic launch,     // owner is in a *_REQ state this cycle
    input  logic waiting,    // owner is in a *_WAIT state this cycle
    input  logic clk_stall,
    output logic req,
    output logic complete,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic             stall_seen_q, stall_seen_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Track whether the responder has acknowledged, and how long we have waited
    always_comb begin
        stall_seen_d = stall_seen_q;
        wait_cnt_d   = wait_cnt_q;
        if (launch) begin
            stall_seen_d = 1'b0;
            wait_cnt_d   = '0;
        end else if (waiting) begin
            if (clk_stall)
                stall_seen_d = 1'b1;
            else if (!stall_seen_q)
                wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Tracker state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_seen_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            stall_seen_q <= stall_seen_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign req      = launch;
    assign complete = waiting && stall_seen_q && !clk_stall;
    // Fires in the TIMEOUT-th wait cycle if the responder never stalled
    assign timeout  = waiting && !stall_seen_q && !clk_stall &&
                      (wait_cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_copy_dma.sv
// Word-copy DMA engine: copies len_words words from src to dst over the
// data-memory port as alternating read/write transactions.
module dmem_copy_dma
    import dmem_copy_dma_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       write_data,
    output logic              memread,
    output logic              memwrite,
    output logic [3:0]        sign_mask,
    input  logic [31:0]       read_data,
    input  logic              clk_stall
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d, words_done_q, words_done_d;
    logic [31:0]       buf_q, buf_d;
    logic              err_q, err_d;

    logic txn_launch, txn_wait, txn_req, txn_complete, txn_timeout;
    logic [LEN_W-1:0] words_next;

    assign txn_launch = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign txn_wait   = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    assign words_next = words_done_q + 1'b1;

    dmem_port_txn #(.TIMEOUT(TIMEOUT)) u_txn (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (txn_launch),
        .waiting   (txn_wait),
        .clk_stall (clk_stall),
        .req       (txn_req),
        .complete  (txn_complete),
        .timeout   (txn_timeout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (start) begin
                    if (len_words == '0)
                        state_d = ST_FINISH;
                    else if (!is_word_aligned(src_addr[1:0]) || !is_word_aligned(dst_addr[1:0]))
                        state_d = ST_ERROR;
                    else
                        state_d = ST_RD_REQ;
                end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT:
                if (txn_timeout)       state_d = ST_ERROR;
                else if (txn_complete) state_d = abort ? ST_FINISH : ST_WR_REQ;
            ST_WR_REQ:  state_d = ST_WR_WAIT;
            ST_WR_WAIT:
                if (txn_timeout)       state_d = ST_ERROR;
                else if (txn_complete) state_d = (words_next == len_q || abort) ? ST_FINISH : ST_RD_REQ;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath: job latch, word buffer, pointer advance, progress and error flag
    always_comb begin
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        len_d        = len_q;
        words_done_d = words_done_q;
        buf_d        = buf_q;
        err_d        = err_q;
        if (state_q == ST_IDLE && start) begin
            src_ptr_d    = src_addr;
            dst_ptr_d    = dst_addr;
            len_d        = len_words;
            words_done_d = '0;
            err_d        = 1'b0;
        end
        if (state_q == ST_RD_WAIT && txn_complete)
            buf_d = read_data;
        if (state_q == ST_WR_WAIT && txn_complete) begin
            src_ptr_d    = src_ptr_q + ADDR_W'(4);
            dst_ptr_d    = dst_ptr_q + ADDR_W'(4);
            words_done_d = words_next;
        end
        // Entering ERROR overrides the clear done on a misaligned start
        if (state_d == ST_ERROR)
            err_d = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            buf_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            len_q        <= len_d;
            words_done_q <= words_done_d;
            buf_q        <= buf_d;
            err_q        <= err_d;
        end
    end

    // Outputs decoded from state; all zero while in reset
    always_comb begin
        busy       = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) ||
                     (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT);
        done       = (state_q == ST_FINISH);
        err        = err_q;
        words_done = words_done_q;
        memread    = txn_req && (state_q == ST_RD_REQ);
        memwrite   = txn_req && (state_q == ST_WR_REQ);
        addr       = '0;
        write_data = '0;
        sign_mask  = '0;
        if (memread) begin
            addr      = src_ptr_q;
            sign_mask = SIGN_MASK_WORD;
        end
        if (memwrite) begin
            addr       = dst_ptr_q;
            write_data = buf_q;
            sign_mask  = SIGN_MASK_WORD;
        end
    end

endmodule

// File: tb/tb_dmem_copy_dma.sv
// Scoreboard bench for dmem_copy_dma with a behavioural memory responder.
module tb_dmem_copy_dma;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic [9:0]  len_words = '0;
    logic        busy, done, err, memread, memwrite;
    logic [9:0]  words_done;
    logic [31:0] addr, write_data;
    logic [3:0]  sign_mask;
    logic [31:0] read_data = '0;
    logic        clk_stall = 1'b0;

    dmem_copy_dma #(.ADDR_W(32), .LEN_W(10), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .addr(addr), .write_data(write_data), .memread(memread), .memwrite(memwrite),
        .sign_mask(sign_mask), .read_data(read_data), .clk_stall(clk_stall)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } txn_t;
    typedef struct { bit is_err; int words; } cpl_t;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, cpl_seen = 0, n_rd = 0, n_wr = 0;
    txn_t exp_txn[$];
    cpl_t exp_cpl[$];
    logic [31:0] mem [int unsigned];
    bit stub = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: required event did not occur as expected", name);
    endfunction

    function automatic logic [31:0] rd_mem(logic [31:0] a);
        int unsigned k = int'(a[31:2]);
        return mem.exists(k) ? mem[k] : 32'h0;
    endfunction

    function automatic void wr_mem(logic [31:0] a, logic [31:0] d);
        int unsigned k = int'(a[31:2]);
        mem[k] = d;
    endfunction

    // Responder: takes the request at the issue cycle, raises clk_stall at that
    // edge, holds it 1..3 cycles, and finishes even if the DMA is reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (memread || memwrite) && !stub) begin
                if (memwrite) wr_mem(addr, write_data);
                else          read_data = rd_mem(addr);
                @(posedge clk); #1 clk_stall = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1 clk_stall = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a request or completes
    initial begin
        bit prev_req = 1'b0, err_prev = 1'b0;
        txn_t t;
        cpl_t c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (memread || memwrite) begin
                    if (memread) n_rd++;
                    if (memwrite) n_wr++;
                    chk("req_one_cycle", {31'b0, prev_req}, 32'd0);
                    chk("sign_mask", {28'b0, sign_mask}, 32'h4);
                    if (exp_txn.size() == 0) fail_now("unexpected_txn");
                    else begin
                        t = exp_txn.pop_front();
                        chk("txn_kind", {31'b0, memwrite}, {31'b0, t.we});
                        chk("txn_addr", addr, t.addr);
                        if (t.we) chk("wr_data", write_data, t.data);
                    end
                end
                if (done || (err && !err_prev)) begin
                    if (exp_cpl.size() == 0) fail_now("unexpected_completion");
                    else begin
                        c = exp_cpl.pop_front();
                        chk("cpl_err", {31'b0, err}, {31'b0, c.is_err});
                        chk("cpl_done", {31'b0, done}, {31'b0, !c.is_err});
                        chk("words_done", {22'b0, words_done}, c.words);
                        chk("busy_at_cpl", {31'b0, busy}, 32'd0);
                    end
                    cpl_seen++;
                end
            end
            prev_req = memread || memwrite;
            err_prev = err;
        end
    end

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int len);
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = 10'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cpl(input int target, input int budget);
        int n = 0;
        while (cpl_seen < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (cpl_seen < target) fail_now("completion_timeout");
    endtask

    function automatic void push_rw(input logic [31:0] s, input logic [31:0] d, input int i, input bit with_wr);
        txn_t t;
        t.we = 1'b0; t.addr = s + 32'(4 * i); t.data = '0;
        exp_txn.push_back(t);
        if (with_wr) begin
            t.we = 1'b1; t.addr = d + 32'(4 * i); t.data = rd_mem(s + 32'(4 * i));
            exp_txn.push_back(t);
        end
    endfunction

    function automatic void push_cpl(input bit is_err, input int words);
        cpl_t c;
        c.is_err = is_err; c.words = words;
        exp_cpl.push_back(c);
    endfunction

    // Full copy: reference result is the source words as seen before the copy
    task automatic copy(input logic [31:0] s, input logic [31:0] d, input int len);
        logic [31:0] vals[$];
        int tgt, r0;
        for (int i = 0; i < len; i++) begin
            vals.push_back(rd_mem(s + 32'(4 * i)));
            push_rw(s, d, i, 1'b1);
        end
        push_cpl(1'b0, len);
        tgt = cpl_seen + 1;
        r0 = n_rd + n_wr;
        pulse_start(s, d, len);
        chk("err_clear_on_start", {31'b0, err}, 32'd0);
        wait_cpl(tgt, 100 + 20 * len);
        chk("txn_count", n_rd + n_wr - r0, 2 * len);
        for (int i = 0; i < len; i++)
            chk("mem_copy", rd_mem(d + 32'(4 * i)), vals[i]);
    endtask

    task automatic fill(input logic [31:0] s, input int len);
        for (int i = 0; i < len; i++) wr_mem(s + 32'(4 * i), $urandom);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt, r0, c0, c1, n;
        logic [31:0] v0, s, d;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_words_done", {22'b0, words_done}, 0);
        chk("rst_memread", {31'b0, memread}, 0);
        chk("rst_memwrite", {31'b0, memwrite}, 0);
        chk("rst_sign_mask", {28'b0, sign_mask}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_write_data", write_data, 0);
        rst_n = 1'b1;

        // Directed copy of 0xA0..A3
        for (int i = 0; i < 4; i++) wr_mem(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
        copy(32'h1000, 32'h1100, 4);

        // len == 0: done on the next cycle, no port activity
        push_cpl(1'b0, 0);
        tgt = cpl_seen + 1; r0 = n_rd + n_wr;
        pulse_start(32'h1000, 32'h1100, 0);
        chk("len0_done_next_cycle", {31'b0, done}, 1);
        chk("len0_err", {31'b0, err}, 0);
        wait_cpl(tgt, 20);
        repeat (3) @(negedge clk);
        chk("len0_no_txn", n_rd + n_wr - r0, 0);

        // Misaligned source: err, no port activity, no done; next valid start clears err
        push_cpl(1'b1, 0);
        tgt = cpl_seen + 1; r0 = n_rd + n_wr;
        pulse_start(32'h1002, 32'h1200, 3);
        wait_cpl(tgt, 20);
        repeat (3) @(negedge clk);
        chk("misalign_no_txn", n_rd + n_wr - r0, 0);
        chk("err_sticky", {31'b0, err}, 1);
        fill(32'h1300, 2);
        copy(32'h1300, 32'h1340, 2);

        // Abort during the second read wait
        fill(32'h1400, 5);
        wr_mem(32'h1504, 32'hDEADBEEF);
        push_rw(32'h1400, 32'h1500, 0, 1'b1);
        push_rw(32'h1400, 32'h1500, 1, 1'b0);
        push_cpl(1'b0, 1);
        v0 = rd_mem(32'h1400);
        tgt = cpl_seen + 1; r0 = n_rd;
        pulse_start(32'h1400, 32'h1500, 5);
        n = 0;
        while (n_rd < r0 + 2 && n < 200) begin @(negedge clk); #1; n++; end
        if (n_rd < r0 + 2) fail_now("abort_second_read");
        @(negedge clk);
        abort = 1'b1;
        wait_cpl(tgt, 100);
        abort = 1'b0;
        chk("abort_word0", rd_mem(32'h1500), v0);
        chk("abort_word1_untouched", rd_mem(32'h1504), 32'hDEADBEEF);
        chk("abort_reads", n_rd - r0, 2);

        // Responder never stalls: timeout error
        stub = 1'b1;
        push_rw(32'h1000, 32'h1600, 0, 1'b0);
        push_cpl(1'b1, 0);
        tgt = cpl_seen + 1;
        pulse_start(32'h1000, 32'h1600, 2);
        c0 = -1000; n = 0;
        while (n < 50) begin if (memread) begin c0 = cyc; break; end @(negedge clk); n++; end
        if (c0 < 0) fail_now("timeout_read_issue");
        c1 = -1; n = 0;
        while (n < 100) begin @(negedge clk); n++; if (err) begin c1 = cyc; break; end end
        chk("timeout_cycles", c1 - c0, TIMEOUT + 1);
        chk("timeout_busy", {31'b0, busy}, 0);
        wait_cpl(tgt, 20);
        stub = 1'b0;

        // Async reset during a write wait; the issued write still lands
        fill(32'h1700, 3);
        for (int i = 0; i < 3; i++) push_rw(32'h1700, 32'h1800, i, 1'b1);
        push_cpl(1'b0, 3);
        v0 = rd_mem(32'h1700);
        r0 = n_wr;
        pulse_start(32'h1700, 32'h1800, 3);
        n = 0;
        while (n_wr == r0 && n < 100) begin @(negedge clk); #1; n++; end
        if (n_wr == r0) fail_now("reset_first_write");
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_memwrite", {31'b0, memwrite}, 0);
        chk("arst_memread", {31'b0, memread}, 0);
        chk("arst_addr", addr, 0);
        chk("arst_sign_mask", {28'b0, sign_mask}, 0);
        chk("arst_words_done", {22'b0, words_done}, 0);
        exp_txn.delete();
        exp_cpl.delete();
        repeat (8) @(negedge clk);
        chk("arst_write_landed", rd_mem(32'h1800), v0);
        rst_n = 1'b1;
        fill(32'h1900, 2);
        copy(32'h1900, 32'h1A00, 2);

        // Randomized copies over disjoint regions
        for (int k = 0; k < 6; k++) begin
            s = 32'h4000 + 32'($urandom_range(0, 63) * 4);
            d = 32'h8000 + 32'($urandom_range(0, 63) * 4);
            n = $urandom_range(1, 8);
            fill(s, n);
            copy(s, d, n);
        end

        // Source pointer wraps past the top of the address space; dst hits the LED register
        fill(32'hFFFF_FFF8, 3);
        copy(32'hFFFF_FFF8, 32'h2000, 3);

        repeat (5) @(negedge clk);
        if (exp_txn.size() != 0) fail_now("leftover_txn");
        if (exp_cpl.size() != 0) fail_now("leftover_completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
